// File: rtl/map_port_arbiter.sv
// Two-requester arbiter for the shared combinational map lookup port.
// Tracer (A) and overlay (B) get registered, fixed-latency responses in acceptance order.
module map_port_arbiter #(
  parameter int BITS       = 2,
  parameter int COORD_W    = 4,
  parameter int STARVE_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trace_phase,
  input  logic               a_req,
  input  logic [COORD_W-1:0] a_row,
  input  logic [COORD_W-1:0] a_col,
  output logic               a_gnt,
  output logic               a_rvalid,
  output logic [BITS-1:0]    a_rdata,
  input  logic               b_req,
  input  logic [COORD_W-1:0] b_row,
  input  logic [COORD_W-1:0] b_col,
  output logic               b_gnt,
  output logic               b_rvalid,
  output logic [BITS-1:0]    b_rdata,
  output logic [COORD_W-1:0] map_row,
  output logic [COORD_W-1:0] map_col,
  input  logic [BITS-1:0]    map_val
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  owner_t           last;
  owner_t           owner_p0;
  logic             vld_p0;
  logic [CNT_W-1:0] a_cnt;
  logic [CNT_W-1:0] b_cnt;
  logic             a_starved;
  logic             b_starved;
  logic             xfer_a;
  logic             xfer_b;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(STARVE_MAX)) ? c : c + CNT_W'(1);
  endfunction

  assign a_starved = (a_cnt == CNT_W'(STARVE_MAX));
  assign b_starved = (b_cnt == CNT_W'(STARVE_MAX));

  // Grant is combinational and forced low while reset is asserted.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      if (a_req && !b_req) begin
        a_gnt = 1'b1;
      end else if (b_req && !a_req) begin
        b_gnt = 1'b1;
      end else if (a_req && b_req) begin
        if (a_starved)             a_gnt = 1'b1;
        else if (b_starved)        b_gnt = 1'b1;
        else if (trace_phase)      a_gnt = 1'b1;
        else if (last == OWN_B)    a_gnt = 1'b1;
        else                       b_gnt = 1'b1;
      end
    end
  end

  assign xfer_a = a_req && a_gnt;
  assign xfer_b = b_req && b_gnt;

  // Arbitration state: pointer moves only on contested transfers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last  <= OWN_B;
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (a_req && b_req && (xfer_a || xfer_b))
        last <= xfer_b ? OWN_B : OWN_A;
      if (xfer_a)     a_cnt <= '0;
      else if (a_req) a_cnt <= sat_inc(a_cnt);
      if (xfer_b)     b_cnt <= '0;
      else if (b_req) b_cnt <= sat_inc(b_cnt);
    end
  end

  // Stage p0: registered lookup address and owner of the in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      map_row  <= '0;
      map_col  <= '0;
      owner_p0 <= OWN_A;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= xfer_a || xfer_b;
      if (xfer_a) begin
        map_row  <= a_row;
        map_col  <= a_col;
        owner_p0 <= OWN_A;
      end else if (xfer_b) begin
        map_row  <= b_row;
        map_col  <= b_col;
        owner_p0 <= OWN_B;
      end
    end
  end

  // Stage p1: capture the cell value for the owner; the other requester's data holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= vld_p0 && (owner_p0 == OWN_A);
      b_rvalid <= vld_p0 && (owner_p0 == OWN_B);
      if (vld_p0 && (owner_p0 == OWN_A)) a_rdata <= map_val;
      if (vld_p0 && (owner_p0 == OWN_B)) b_rdata <= map_val;
    end
  end

endmodule
